regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_slot.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths, slot identifiers and decode helper for the regfile writeback arbiter.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int STALL_W    = 16;

    localparam logic SLOT_A = 1'b0;
    localparam logic SLOT_B = 1'b1;

    // One-hot decode of a register index into a 32-bit mask.
    function automatic logic [DATA_W-1:0] oneHot(input logic [REG_ADDR_W-1:0] regIdx);
        logic [DATA_W-1:0] mask;
        mask = '0;
        mask[regIdx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback buffer: holds a destination register and data until cleared.
module wb_slot
    import regfile_wb_pkg::*;
(
    input  logic                  iwClk,
    input  logic                  iwnRst,
    input  logic                  iwLoad,
    input  logic                  iwClear,
    input  logic [REG_ADDR_W-1:0] iwReg,
    input  logic [DATA_W-1:0]     iwData,
    output logic                  owFull,
    output logic [REG_ADDR_W-1:0] owReg,
    output logic [DATA_W-1:0]     owData
);

    // A load wins over a clear so a granted slot can be refilled on the same edge.
    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            owFull <= 1'b0;
            owReg  <= '0;
            owData <= '0;
        end else if (iwLoad) begin
            owFull <= 1'b1;
            owReg  <= iwReg;
            owData <= iwData;
        end else if (iwClear) begin
            owFull <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester regfile writeback arbiter: one buffered slot per requester,
// oldest-first grant with a round-robin tie break, and a saturating stall counter.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter logic pZeroDrop = 1'b1
) (
    input  logic                  iwClk,
    input  logic                  iwnRst,
    input  logic                  iwAValid,
    input  logic [REG_ADDR_W-1:0] iwAReg,
    input  logic [DATA_W-1:0]     iwAData,
    output logic                  owAReady,
    input  logic                  iwBValid,
    input  logic [REG_ADDR_W-1:0] iwBReg,
    input  logic [DATA_W-1:0]     iwBData,
    output logic                  owBReady,
    output logic                  owWriteEnable,
    output logic [REG_ADDR_W-1:0] owWriteReg,
    output logic [DATA_W-1:0]     owWriteData,
    output logic [DATA_W-1:0]     owPendingMask,
    output logic [STALL_W-1:0]    owStallCount
);

    logic                  aFull, bFull;
    logic [REG_ADDR_W-1:0] aReg, bReg;
    logic [DATA_W-1:0]     aData, bData;
    logic                  aZero, bZero, aElig, bElig;
    logic                  aLoad, bLoad, aClear, bClear;
    logic                  grantValid, grantSel, tieGrant, grantA, grantB;
    logic                  olderSlot, tieFlag, rrPtr;
    logic [1:0]            refuseCount;
    logic [STALL_W:0]      stallSum;

    wb_slot slotA (
        .iwClk(iwClk), .iwnRst(iwnRst), .iwLoad(aLoad), .iwClear(aClear),
        .iwReg(iwAReg), .iwData(iwAData),
        .owFull(aFull), .owReg(aReg), .owData(aData)
    );

    wb_slot slotB (
        .iwClk(iwClk), .iwnRst(iwnRst), .iwLoad(bLoad), .iwClear(bClear),
        .iwReg(iwBReg), .iwData(iwBData),
        .owFull(bFull), .owReg(bReg), .owData(bData)
    );

    // Pick one eligible slot: oldest first, round-robin when both loaded together.
    always_comb begin
        aZero      = pZeroDrop && aFull && (aReg == '0);
        bZero      = pZeroDrop && bFull && (bReg == '0);
        aElig      = iwnRst && aFull && !aZero;
        bElig      = iwnRst && bFull && !bZero;
        grantValid = 1'b0;
        grantSel   = SLOT_A;
        tieGrant   = 1'b0;
        if (aElig && bElig) begin
            grantValid = 1'b1;
            if (tieFlag) begin
                grantSel = rrPtr;
                tieGrant = 1'b1;
            end else begin
                grantSel = olderSlot;
            end
        end else if (aElig) begin
            grantValid = 1'b1;
            grantSel   = SLOT_A;
        end else if (bElig) begin
            grantValid = 1'b1;
            grantSel   = SLOT_B;
        end
        grantA = grantValid && (grantSel == SLOT_A);
        grantB = grantValid && (grantSel == SLOT_B);
    end

    // Handshake, slot control and writeback outputs; reset forces the idle view.
    always_comb begin
        owAReady      = !iwnRst || !aFull || grantA;
        owBReady      = !iwnRst || !bFull || grantB;
        aLoad         = iwAValid && owAReady;
        bLoad         = iwBValid && owBReady;
        aClear        = grantA || aZero;
        bClear        = grantB || bZero;
        owWriteEnable = grantValid;
        owWriteReg    = '0;
        owWriteData   = '0;
        if (grantA) begin
            owWriteReg  = aReg;
            owWriteData = aData;
        end else if (grantB) begin
            owWriteReg  = bReg;
            owWriteData = bData;
        end
        owPendingMask = '0;
        if (iwnRst) begin
            owPendingMask = ((aFull ? oneHot(aReg) : '0) | (bFull ? oneHot(bReg) : '0))
                            & ~{{(DATA_W-1){1'b0}}, 1'b1};
        end
        refuseCount = {1'b0, iwAValid && !owAReady} + {1'b0, iwBValid && !owBReady};
        stallSum    = {1'b0, owStallCount} + {{(STALL_W-1){1'b0}}, refuseCount};
    end

    // Track which slot loaded first, whether they loaded together, and the tie pointer.
    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            olderSlot <= SLOT_A;
            tieFlag   <= 1'b0;
            rrPtr     <= SLOT_A;
        end else begin
            if (aLoad && bLoad) begin
                tieFlag <= 1'b1;
            end else if (aLoad) begin
                tieFlag   <= 1'b0;
                olderSlot <= SLOT_B;
            end else if (bLoad) begin
                tieFlag   <= 1'b0;
                olderSlot <= SLOT_A;
            end
            if (tieGrant) begin
                rrPtr <= ~rrPtr;
            end
        end
    end

    // Count refused requests, sticking at the all-ones value.
    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            owStallCount <= '0;
        end else if (stallSum[STALL_W]) begin
            owStallCount <= '1;
        end else begin
            owStallCount <= stallSum[STALL_W-1:0];
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b0;
    logic        iwAValid = 1'b0, iwBValid = 1'b0;
    logic [4:0]  iwAReg = '0, iwBReg = '0;
    logic [31:0] iwAData = '0, iwBData = '0;
    logic        owAReady, owBReady, owWriteEnable;
    logic [4:0]  owWriteReg;
    logic [31:0] owWriteData, owPendingMask;
    logic [15:0] owStallCount;

    int testCount = 0;
    int failCount = 0;

    regfile_wb_arbiter #(.pZeroDrop(1'b1)) dut (
        .iwClk(iwClk), .iwnRst(iwnRst),
        .iwAValid(iwAValid), .iwAReg(iwAReg), .iwAData(iwAData), .owAReady(owAReady),
        .iwBValid(iwBValid), .iwBReg(iwBReg), .iwBData(iwBData), .owBReady(owBReady),
        .owWriteEnable(owWriteEnable), .owWriteReg(owWriteReg), .owWriteData(owWriteData),
        .owPendingMask(owPendingMask), .owStallCount(owStallCount)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 iwClk = ~iwClk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive both requester inputs in one call.
    task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                                 input logic bV, input logic [4:0] bR, input logic [31:0] bD);
        iwAValid = aV; iwAReg = aR; iwAData = aD;
        iwBValid = bV; iwBReg = bR; iwBData = bD;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge iwClk);
        #1;
    endtask

    // Hold reset for two edges with idle inputs, then release it.
    task automatic doReset();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        iwnRst = 1'b0;
        tick();
        tick();
        iwnRst = 1'b1;
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_we", owWriteEnable, 0);
        checkOutput("rst_reg", owWriteReg, 0);
        checkOutput("rst_data", owWriteData, 0);
        checkOutput("rst_mask", owPendingMask, 0);
        checkOutput("rst_ardy", owAReady, 1);
        checkOutput("rst_brdy", owBReady, 1);
        checkOutput("rst_stall", owStallCount, 0);

        // Single write from A
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("single_we", owWriteEnable, 1);
        checkOutput("single_reg", owWriteReg, 5);
        checkOutput("single_data", owWriteData, 32'hDEADBEEF);
        checkOutput("single_mask", owPendingMask, 32'h20);
        tick();
        checkOutput("single_we_after", owWriteEnable, 0);
        checkOutput("single_mask_after", owPendingMask, 0);
        checkOutput("single_data_after", owWriteData, 0);

        // Age order on the same register
        doReset();
        applyStimulus(1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd2);
        checkOutput("age_brdy1", owBReady, 1);
        checkOutput("age_we1", owWriteEnable, 1);
        checkOutput("age_reg1", owWriteReg, 3);
        checkOutput("age_data1", owWriteData, 1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("age_brdy2", owBReady, 1);
        checkOutput("age_we2", owWriteEnable, 1);
        checkOutput("age_reg2", owWriteReg, 3);
        checkOutput("age_data2", owWriteData, 2);
        tick();
        checkOutput("age_we3", owWriteEnable, 0);

        // Tie and round-robin with both requesters always valid
        doReset();
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
        tick();
        checkOutput("rr_c2_reg", owWriteReg, 1);
        checkOutput("rr_c2_ardy", owAReady, 1);
        checkOutput("rr_c2_brdy", owBReady, 0);
        checkOutput("rr_c2_stall", owStallCount, 0);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
        tick();
        checkOutput("rr_c3_reg", owWriteReg, 9);
        checkOutput("rr_c3_ardy", owAReady, 0);
        checkOutput("rr_c3_brdy", owBReady, 1);
        checkOutput("rr_c3_stall", owStallCount, 1);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hAA);
        tick();
        checkOutput("rr_c4_reg", owWriteReg, 2);
        checkOutput("rr_c4_data", owWriteData, 32'h22);
        checkOutput("rr_c4_stall", owStallCount, 2);
        tick();
        checkOutput("rr_c5_reg", owWriteReg, 10);
        checkOutput("rr_c5_data", owWriteData, 32'hAA);
        checkOutput("rr_c5_stall", owStallCount, 3);

        // Zero-register drop does not block the other slot
        doReset();
        applyStimulus(1'b1, 5'd0, 32'd7, 1'b1, 5'd4, 32'd8);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("zero_we", owWriteEnable, 1);
        checkOutput("zero_reg", owWriteReg, 4);
        checkOutput("zero_data", owWriteData, 8);
        checkOutput("zero_mask", owPendingMask, 32'h10);
        tick();
        checkOutput("zero_we_after", owWriteEnable, 0);
        checkOutput("zero_mask_after", owPendingMask, 0);
        checkOutput("zero_ardy_after", owAReady, 1);

        // Reset asserted while both slots hold writes
        doReset();
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
        tick();
        tick();
        checkOutput("mrst_stall_pre", owStallCount, 1);
        iwnRst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("mrst_we_during", owWriteEnable, 0);
        checkOutput("mrst_ardy_during", owAReady, 1);
        tick();
        iwnRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("mrst_we", owWriteEnable, 0);
            checkOutput("mrst_mask", owPendingMask, 0);
            checkOutput("mrst_stall", owStallCount, 0);
            checkOutput("mrst_ardy", owAReady, 1);
            checkOutput("mrst_brdy", owBReady, 1);
            tick();
        end

        // Saturation: one refusal per cycle once both slots are busy
        doReset();
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int k = 1; k <= 70000; k++) begin
            tick();
            if (k == 1000) checkOutput("sat_mid", owStallCount, 999);
        end
        checkOutput("sat_final", owStallCount, 16'hFFFF);
        tick();
        checkOutput("sat_hold", owStallCount, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
